// File: rtl/cache_pkg.sv
// Shared types and address helpers for the per-pixel-core read cache controller.
package cache_pkg;

    localparam int SIZE_BLOCK      = 32;
    localparam int BIT_TOTAL       = 24;
    localparam int BIT_INDEX       = 8;
    localparam int MEM_ADDR_W      = 32;
    localparam int BYTES_PER_BLOCK = SIZE_BLOCK / 8;
    localparam int BLK_SHIFT       = $clog2(BYTES_PER_BLOCK);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        CHECK    = 3'd2,
        RESP     = 3'd3,
        MEM_REQ  = 3'd4,
        MEM_WAIT = 3'd5,
        FILL     = 3'd6,
        FLUSH    = 3'd7
    } cache_ctrl_state_e;

    // Block index to SDRAM byte address; the sum wraps at MEM_ADDR_W bits.
    function automatic logic [MEM_ADDR_W-1:0] blk2byte(
        input logic [BIT_TOTAL-1:0]  index,
        input logic [MEM_ADDR_W-1:0] base
    );
        logic [MEM_ADDR_W-1:0] ext_v;
        ext_v = MEM_ADDR_W'(index);
        return base + (ext_v << BLK_SHIFT);
    endfunction

endpackage

// File: rtl/cache_read_ctrl_if.sv
// Avalon-MM read-only bus bundle; one instance per side of the controller.
interface cache_read_ctrl_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/cache_ro.sv
// Direct-mapped, block-addressed read-only cache with registered lookup result.
module cache_ro
    import cache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  wrt_i,
    input  logic [BIT_TOTAL-1:0]  addr_i,
    input  logic [SIZE_BLOCK-1:0] wdata_i,
    output logic [SIZE_BLOCK-1:0] rdata_o,
    output logic                  success_o
);
    localparam int TAG_W = BIT_TOTAL - BIT_INDEX;
    localparam int SETS  = 1 << BIT_INDEX;

    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_mem [SETS];
    logic [SIZE_BLOCK-1:0] data_mem [SETS];
    logic [SIZE_BLOCK-1:0] rdata_q;
    logic                  success_q;
    logic [BIT_INDEX-1:0]  idx_s;
    logic [TAG_W-1:0]      tag_s;

    assign idx_s = addr_i[BIT_INDEX-1:0];
    assign tag_s = addr_i[BIT_TOTAL-1:BIT_INDEX];

    // Valid bits and the registered lookup result; reset invalidates every line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= {SETS{1'b0}};
            rdata_q   <= {SIZE_BLOCK{1'b0}};
            success_q <= 1'b0;
        end else if (en_i && wrt_i) begin
            valid_q[idx_s] <= 1'b1;
        end else if (en_i) begin
            rdata_q   <= data_mem[idx_s];
            success_q <= valid_q[idx_s] && (tag_mem[idx_s] == tag_s);
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (en_i && wrt_i) begin
            tag_mem[idx_s]  <= tag_s;
            data_mem[idx_s] <= wdata_i;
        end
    end

    assign rdata_o   = rdata_q;
    assign success_o = success_q;
endmodule

// File: rtl/cache_read_ctrl.sv
// Read-cache controller: serves one slave read at a time, filling from SDRAM on a miss.
module cache_read_ctrl
    import cache_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] MEM_BASE = {MEM_ADDR_W{1'b0}}
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    cache_read_ctrl_if.slave   s_bus,
    cache_read_ctrl_if.master  m_bus,
    output logic [31:0]        o_hits,
    output logic [31:0]        o_misses
);
    cache_ctrl_state_e     state_q, state_d;
    logic [BIT_TOTAL-1:0]  addr_q, addr_d;
    logic [SIZE_BLOCK-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;
    logic                  mread_q, mread_d;
    logic [31:0]           hits_q, hits_d;
    logic [31:0]           misses_q, misses_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  s_wait_s;
    logic                  cache_rst_s, cache_en_s, cache_wrt_s, cache_success_s;
    logic [SIZE_BLOCK-1:0] cache_rdata_s;

    assign cache_rst_s = i_rst | (state_q == FLUSH);

    cache_ro u_cache (
        .clk_i     (i_clk),
        .rst_i     (cache_rst_s),
        .en_i      (cache_en_s),
        .wrt_i     (cache_wrt_s),
        .addr_i    (addr_q),
        .wdata_i   (rdata_q),
        .rdata_o   (cache_rdata_s),
        .success_o (cache_success_s)
    );

    // Next-state, counter and bus-strobe decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        maddr_d      = maddr_q;
        hits_d       = hits_q;
        misses_d     = misses_q;
        flush_pend_d = flush_pend_q | i_flush;
        s_wait_s     = 1'b1;
        cache_en_s   = 1'b0;
        cache_wrt_s  = 1'b0;
        case (state_q)
            IDLE: begin
                // A live i_flush beats a simultaneous request.
                if (flush_pend_q || i_flush) begin
                    flush_pend_d = 1'b0;
                    state_d      = FLUSH;
                end else begin
                    s_wait_s = 1'b0;
                    if (s_bus.read) begin
                        addr_d  = s_bus.address;
                        state_d = LOOKUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOOKUP: begin
                cache_en_s = 1'b1;
                state_d    = CHECK;
            end
            CHECK: begin
                if (cache_success_s) begin
                    rdata_d  = cache_rdata_s;
                    rvalid_d = 1'b1;
                    hits_d   = (hits_q == 32'hFFFF_FFFF) ? hits_q : hits_q + 32'd1;
                    state_d  = RESP;
                end else begin
                    misses_d = (misses_q == 32'hFFFF_FFFF) ? misses_q : misses_q + 32'd1;
                    maddr_d  = blk2byte(addr_q, MEM_BASE);
                    state_d  = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (!m_bus.waitrequest) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                if (m_bus.readdatavalid) begin
                    rdata_d  = m_bus.readdata;
                    rvalid_d = 1'b1;
                    state_d  = FILL;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            FILL: begin
                cache_en_s  = 1'b1;
                cache_wrt_s = 1'b1;
                state_d     = IDLE;
            end
            RESP:    state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mread_d = (state_d == MEM_REQ);
    end

    // Controller state and registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            addr_q       <= {BIT_TOTAL{1'b0}};
            rdata_q      <= {SIZE_BLOCK{1'b0}};
            rvalid_q     <= 1'b0;
            maddr_q      <= {MEM_ADDR_W{1'b0}};
            mread_q      <= 1'b0;
            hits_q       <= 32'd0;
            misses_q     <= 32'd0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            maddr_q      <= maddr_d;
            mread_q      <= mread_d;
            hits_q       <= hits_d;
            misses_q     <= misses_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign s_bus.waitrequest   = s_wait_s | i_rst;
    assign s_bus.readdata      = rdata_q;
    assign s_bus.readdatavalid = rvalid_q;
    assign m_bus.address       = maddr_q;
    assign m_bus.read          = mread_q;
    assign o_hits              = hits_q;
    assign o_misses            = misses_q;
endmodule
